// File: rtl/segbank.sv
// segbank: segment-base register bank with a save/restore context stack and a
// registered base+offset effective address. Define SEGBANK_LIMIT_EN for limit faults.
module segbank #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned NSEG   = 4,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned OFF_W  = 12,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              load_i,
  input  logic [SEL_W-1:0]  load_sel_i,
  input  logic [ADDR_W-1:0] load_data_i,
  input  logic              lim_load_i,
  input  logic              push_i,
  input  logic [SEL_W-1:0]  push_sel_i,
  input  logic              pop_i,
  input  logic              rd_req_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic              err_clr_i,
  output logic              ea_valid_o,
  output logic [ADDR_W-1:0] ea_o,
  output logic              ea_ovf_o,
  output logic              ea_fault_o,
  output logic [CNT_W-1:0]  stk_count_o,
  output logic              stk_full_o,
  output logic              stk_empty_o,
  output logic              stk_err_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SUM_W = ADDR_W + 1;

  logic [ADDR_W-1:0] base_q [NSEG];
  logic [ADDR_W-1:0] base_d [NSEG];
  logic [SEL_W-1:0]  stk_sel_q  [DEPTH];
  logic [ADDR_W-1:0] stk_base_q [DEPTH];

  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d, err_q, err_d;
  logic              valid_q, valid_d, ovf_q, ovf_d, fault_q, fault_d;
  logic [ADDR_W-1:0] ea_q, ea_d;

  logic              push_ok, pop_ok, stk_bad, rd_fault;
  logic [IDX_W-1:0]  push_idx, pop_idx;
  logic [SEL_W-1:0]  top_sel;
  logic [ADDR_W-1:0] top_base, rd_base, push_base;
  logic [SUM_W-1:0]  sum;

  assign stk_bad  = (push_i & pop_i) | (push_i & full_q) | (pop_i & empty_q);
  assign push_ok  = push_i & ~pop_i & ~full_q;
  assign pop_ok   = pop_i & ~push_i & ~empty_q;
  assign push_idx = IDX_W'(count_q);
  assign pop_idx  = IDX_W'(count_q - CNT_W'(1));
  assign top_sel  = stk_sel_q[pop_idx];
  assign top_base = stk_base_q[pop_idx];
  assign sum      = {1'b0, rd_base} + SUM_W'(offset_i);

  // Pre-edge base lookup; unmapped selects read as base 0.
  always_comb begin
    rd_base   = '0;
    push_base = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (rd_sel_i == SEL_W'(i))   rd_base   = base_q[i];
      if (push_sel_i == SEL_W'(i)) push_base = base_q[i];
    end
  end

  // A restoring pop overrides a same-cycle load to the same segment.
  always_comb begin
    for (int i = 0; i < NSEG; i++) begin
      base_d[i] = base_q[i];
      if (load_i && load_sel_i == SEL_W'(i)) base_d[i] = load_data_i;
      if (pop_ok && top_sel == SEL_W'(i))    base_d[i] = top_base;
    end
  end

`ifdef SEGBANK_LIMIT_EN
  logic [OFF_W-1:0] lim_q [NSEG];
  logic [OFF_W-1:0] lim_d [NSEG];
  logic [OFF_W-1:0] rd_lim;

  always_comb begin
    rd_lim = '1;
    for (int i = 0; i < NSEG; i++) begin
      lim_d[i] = lim_q[i];
      if (lim_load_i && load_sel_i == SEL_W'(i)) lim_d[i] = load_data_i[OFF_W-1:0];
      if (rd_sel_i == SEL_W'(i)) rd_lim = lim_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NSEG; i++) lim_q[i] <= '1;
    end else begin
      for (int i = 0; i < NSEG; i++) lim_q[i] <= lim_d[i];
    end
  end

  assign rd_fault = (offset_i > rd_lim);
`else
  logic unused_lim;
  assign unused_lim = lim_load_i;
  assign rd_fault   = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    if (push_ok)     count_d = count_q + CNT_W'(1);
    else if (pop_ok) count_d = count_q - CNT_W'(1);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    err_d   = err_q;
    if (stk_bad)        err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    valid_d = rd_req_i;
    ea_d    = ea_q;
    ovf_d   = ovf_q;
    fault_d = fault_q;
    if (rd_req_i) begin
      ea_d    = sum[ADDR_W-1:0];
      ovf_d   = sum[ADDR_W];
      fault_d = rd_fault;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NSEG; i++) base_q[i] <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ea_q    <= '0;
      ovf_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      for (int i = 0; i < NSEG; i++) base_q[i] <= base_d[i];
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ea_q    <= ea_d;
      ovf_q   <= ovf_d;
      fault_q <= fault_d;
    end
  end

  // Stack payload needs no reset; only the count qualifies it.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      stk_sel_q[push_idx]  <= push_sel_i;
      stk_base_q[push_idx] <= push_base;
    end
  end

  assign ea_valid_o  = valid_q;
  assign ea_o        = ea_q;
  assign ea_ovf_o    = ovf_q;
  assign ea_fault_o  = fault_q;
  assign stk_count_o = count_q;
  assign stk_full_o  = full_q;
  assign stk_empty_o = empty_q;
  assign stk_err_o   = err_q;

endmodule

// File: tb/tb_segbank.sv
// Table-driven bench for segbank: per-cycle input/expected-output vectors plus
// a hand-written asynchronous reset sequence.
module tb_segbank;

`ifdef SEGBANK_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic        clk, reset_n;
  logic        load, lim_load, push, pop, rd_req, err_clr;
  logic [1:0]  load_sel, push_sel, rd_sel;
  logic [19:0] load_data;
  logic [11:0] offset;
  logic        ea_valid, ea_ovf, ea_fault, stk_full, stk_empty, stk_err;
  logic [19:0] ea;
  logic [2:0]  stk_count;

  int checks = 0;
  int errors = 0;

  segbank dut (
    .clk_i(clk), .reset_ni(reset_n),
    .load_i(load), .load_sel_i(load_sel), .load_data_i(load_data),
    .lim_load_i(lim_load), .push_i(push), .push_sel_i(push_sel), .pop_i(pop),
    .rd_req_i(rd_req), .rd_sel_i(rd_sel), .offset_i(offset), .err_clr_i(err_clr),
    .ea_valid_o(ea_valid), .ea_o(ea), .ea_ovf_o(ea_ovf), .ea_fault_o(ea_fault),
    .stk_count_o(stk_count), .stk_full_o(stk_full), .stk_empty_o(stk_empty),
    .stk_err_o(stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        load;
    bit [1:0]  lsel;
    bit [19:0] ldata;
    bit        lim;
    bit        push;
    bit [1:0]  psel;
    bit        pop;
    bit        rd;
    bit [1:0]  rsel;
    bit [11:0] off;
    bit        clr;
    bit        e_valid;
    bit [19:0] e_ea;
    bit        e_ovf;
    bit        e_fault;
    bit [2:0]  e_cnt;
    bit        e_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input bit ld, input bit [1:0] ls, input bit [19:0] dat,
                              input bit lm, input bit ps, input bit [1:0] pss,
                              input bit pp, input bit rq, input bit [1:0] rs,
                              input bit [11:0] of, input bit cl, input bit ev,
                              input bit [19:0] eea, input bit eo, input bit ef,
                              input bit [2:0] ec, input bit ee);
    vec_t v;
    v = '{ld, ls, dat, lm, ps, pss, pp, rq, rs, of, cl, ev, eea, eo, ef, ec, ee};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    load = 0; load_sel = 0; load_data = 0; lim_load = 0; push = 0; push_sel = 0;
    pop = 0; rd_req = 0; rd_sel = 0; offset = 0; err_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    idle();
    reset_n = 1'b0;

    //        ld ls dat       lm ps pss pp rq rs off     cl  ev ea        ov flt cnt er
    vq.push_back(mk(1, 0, 20'h01000, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 20'h00000, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 0, 1, 0, 12'h010, 0, 1, 20'h01010, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 20'hFFFF0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 20'h01010, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 0, 1, 1, 12'h020, 0, 1, 20'h00010, 1, 0, 0, 0));
    vq.push_back(mk(1, 2, 20'h00300, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 20'h00010, 1, 0, 0, 0));
    vq.push_back(mk(1, 2, 20'h00400, 0, 1, 2, 0, 0, 0, 12'h000, 0, 0, 20'h00010, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 0, 1, 2, 12'h000, 0, 1, 20'h00400, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 1, 0, 0, 12'h000, 0, 0, 20'h00400, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 0, 1, 2, 12'h000, 0, 1, 20'h00300, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 20'h000FF, 1, 0, 0, 0, 0, 0, 12'h000, 0, 0, 20'h00300, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 0, 1, 0, 12'h100, 0, 1, 20'h01100, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 0, 1, 0, 12'h0FF, 0, 1, 20'h010FF, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 0, 1, 3, 12'hFFF, 0, 1, 20'h00FFF, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++)
      vq.push_back(mk(0, 0, 20'h0, 0, 1, 0, 0, 0, 0, 12'h0, 0, 0, 20'h00FFF, 0, 0, 3'(k), 0));
    vq.push_back(mk(0, 0, 20'h00000, 0, 1, 0, 0, 0, 0, 12'h000, 0, 0, 20'h00FFF, 0, 0, 4, 1));
    vq.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 0, 0, 0, 12'h000, 1, 0, 20'h00FFF, 0, 0, 4, 0));
    vq.push_back(mk(0, 0, 20'h00000, 0, 1, 0, 0, 0, 0, 12'h000, 1, 0, 20'h00FFF, 0, 0, 4, 1));
    vq.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 0, 0, 0, 12'h000, 1, 0, 20'h00FFF, 0, 0, 4, 0));
    for (int k = 3; k >= 0; k--)
      vq.push_back(mk(0, 0, 20'h0, 0, 0, 0, 1, 0, 0, 12'h0, 0, 0, 20'h00FFF, 0, 0, 3'(k), 0));
    vq.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 1, 0, 0, 12'h000, 0, 0, 20'h00FFF, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 0, 0, 0, 12'h000, 1, 0, 20'h00FFF, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 20'h00000, 0, 1, 1, 0, 0, 0, 12'h000, 0, 0, 20'h00FFF, 0, 0, 1, 0));
    vq.push_back(mk(1, 3, 20'h00050, 0, 1, 1, 1, 0, 0, 12'h000, 0, 0, 20'h00FFF, 0, 0, 1, 1));
    vq.push_back(mk(1, 1, 20'h12345, 0, 0, 0, 1, 1, 1, 12'h000, 0, 1, 20'hFFFF0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 0, 1, 1, 12'h000, 0, 1, 20'hFFFF0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 0, 1, 3, 12'h005, 0, 1, 20'h00055, 0, 0, 0, 1));

    #12;
    chk("reset ea_valid", 32'(ea_valid), 0);
    chk("reset ea", 32'(ea), 0);
    chk("reset ea_ovf", 32'(ea_ovf), 0);
    chk("reset ea_fault", 32'(ea_fault), 0);
    chk("reset stk_count", 32'(stk_count), 0);
    chk("reset stk_empty", 32'(stk_empty), 1);
    chk("reset stk_full", 32'(stk_full), 0);
    chk("reset stk_err", 32'(stk_err), 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      v = vq[i];
      load = v.load; load_sel = v.lsel; load_data = v.ldata; lim_load = v.lim;
      push = v.push; push_sel = v.psel; pop = v.pop; rd_req = v.rd;
      rd_sel = v.rsel; offset = v.off; err_clr = v.clr;
      step();
      chk($sformatf("row%0d ea_valid", i), 32'(ea_valid), 32'(v.e_valid));
      chk($sformatf("row%0d ea", i), 32'(ea), 32'(v.e_ea));
      chk($sformatf("row%0d ea_ovf", i), 32'(ea_ovf), 32'(v.e_ovf));
      chk($sformatf("row%0d ea_fault", i), 32'(ea_fault), 32'(v.e_fault & LIM));
      chk($sformatf("row%0d stk_count", i), 32'(stk_count), 32'(v.e_cnt));
      chk($sformatf("row%0d stk_full", i), 32'(stk_full), 32'(v.e_cnt == 3'd4));
      chk($sformatf("row%0d stk_empty", i), 32'(stk_empty), 32'(v.e_cnt == 3'd0));
      chk($sformatf("row%0d stk_err", i), 32'(stk_err), 32'(v.e_err));
    end

    // Asynchronous reset landing mid-cycle while a push and rd_req are active.
    idle();
    load = 1; load_sel = 0; load_data = 20'hABCDE;
    step();
    idle();
    push = 1; push_sel = 0; rd_req = 1; rd_sel = 0; offset = 12'h001;
    step();
    chk("pre-reset ea_valid", 32'(ea_valid), 1);
    chk("pre-reset ea", 32'(ea), 32'h000ABCDF);
    chk("pre-reset stk_count", 32'(stk_count), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset ea_valid", 32'(ea_valid), 0);
    chk("async reset ea", 32'(ea), 0);
    chk("async reset stk_count", 32'(stk_count), 0);
    chk("async reset stk_empty", 32'(stk_empty), 1);
    chk("async reset stk_err", 32'(stk_err), 0);
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      rd_req = 1; rd_sel = 2'(s); offset = 12'h000;
      step();
      chk($sformatf("post-reset base%0d", s), 32'(ea), 0);
      chk($sformatf("post-reset valid%0d", s), 32'(ea_valid), 1);
    end
    idle();
    step();
    chk("post-reset ea_valid drop", 32'(ea_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
